// File: rtl/linear_layer_ctrl.sv
// Fully-connected layer sequencer: walks input features per output neuron, drives the MAC, writes results.
// Optional build macro LINEAR_CTRL_RELU_EN clamps negative results to zero on the result write path.
module linear_layer_ctrl #(
    parameter int N_IN     = 288,
    parameter int N_OUT    = 10,
    parameter int W_ADDR_W = 12,
    parameter int O_ADDR_W = 4
) (
    input  logic                       clk,
    input  logic                       rst_b,
    input  logic                       start,
    output logic                       busy,
    output logic                       done,
    output logic [8:0]                 in_addr,
    output logic [W_ADDR_W-1:0]        w_addr,
    output logic [O_ADDR_W-1:0]        b_addr,
    output logic                       mac_en,
    output logic [8:0]                 mac_iter,
    input  logic signed [31:0]         acc_in,
    output logic                       res_we,
    output logic [O_ADDR_W-1:0]        res_addr,
    output logic signed [31:0]         res_data
);

    // Handshake: start is a level sampled only in IDLE; busy spans RUN entry to DONE exit; done pulses once.

    typedef enum logic [2:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN,
        S_WRITE,
        S_DONE
    } state_t;

    localparam logic [8:0]          LAST_IN  = 9'(N_IN - 1);
    localparam logic [O_ADDR_W-1:0] LAST_OUT = O_ADDR_W'(N_OUT - 1);

    state_t                state, state_nx;
    logic [8:0]            in_idx;
    logic [O_ADDR_W-1:0]   out_idx;
    logic [W_ADDR_W-1:0]   w_cnt;
    logic signed [31:0]    res_val;

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:  if (start) state_nx = S_RUN;
            S_RUN:   if (in_idx == LAST_IN) state_nx = S_DRAIN;
            S_DRAIN: state_nx = S_WRITE;
            S_WRITE: state_nx = (out_idx == LAST_OUT) ? S_DONE : S_RUN;
            S_DONE:  state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    // w_cnt runs straight through each neuron, so after its last feature it already holds the next base.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            in_idx  <= '0;
            out_idx <= '0;
            w_cnt   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    in_idx  <= '0;
                    out_idx <= '0;
                    w_cnt   <= '0;
                end
                S_RUN: begin
                    in_idx <= (in_idx == LAST_IN) ? 9'd0 : in_idx + 9'd1;
                    w_cnt  <= w_cnt + 1'b1;
                end
                S_WRITE: begin
                    if (out_idx != LAST_OUT) out_idx <= out_idx + 1'b1;
                end
                S_DONE: begin
                    out_idx <= '0;
                    w_cnt   <= '0;
                end
                default: ;
            endcase
        end
    end

    // Delay by one cycle so the MAC strobe lines up with synchronous-read memory data.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            mac_en   <= 1'b0;
            mac_iter <= '0;
        end else begin
            mac_en   <= (state == S_RUN);
            mac_iter <= in_idx;
        end
    end

    always_comb begin
`ifdef LINEAR_CTRL_RELU_EN
        res_val = acc_in[31] ? 32'sd0 : acc_in;
`else
        res_val = acc_in;
`endif
    end

    always_comb begin
        busy     = (state != S_IDLE);
        done     = (state == S_DONE);
        in_addr  = in_idx;
        w_addr   = w_cnt;
        b_addr   = out_idx;
        res_we   = (state == S_WRITE);
        res_addr = '0;
        res_data = '0;
        if (state == S_WRITE) begin
            res_addr = out_idx;
            res_data = res_val;
        end
    end

endmodule

// File: tb/tb_linear_layer_ctrl.sv
// Bench for linear_layer_ctrl: two configurations, memories and a MAC around each, timing model plus literals.
module tb_linear_layer_ctrl;

    localparam int NA_IN = 4;
    localparam int NA_OUT = 2;
    localparam int NB_IN = 1;
    localparam int NB_OUT = 3;

    logic clk = 1'b0;
    logic rst_b = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- instance a (4 x 2) ----------------
    logic               start_a = 1'b0, busy_a, done_a, mac_en_a, res_we_a;
    logic [8:0]         in_addr_a, mac_iter_a;
    logic [11:0]        w_addr_a;
    logic [3:0]         b_addr_a, res_addr_a;
    logic signed [31:0] acc_a = 0, res_data_a;
    logic signed [31:0] a_data[16], a_w[16], a_b[16];
    logic signed [31:0] a_dq = 0, a_wq = 0, a_bq = 0;

    linear_layer_ctrl #(.N_IN(NA_IN), .N_OUT(NA_OUT), .W_ADDR_W(12), .O_ADDR_W(4)) dut_a (
        .clk(clk), .rst_b(rst_b), .start(start_a), .busy(busy_a), .done(done_a),
        .in_addr(in_addr_a), .w_addr(w_addr_a), .b_addr(b_addr_a),
        .mac_en(mac_en_a), .mac_iter(mac_iter_a), .acc_in(acc_a),
        .res_we(res_we_a), .res_addr(res_addr_a), .res_data(res_data_a)
    );

    always @(posedge clk) begin
        a_dq <= a_data[in_addr_a[3:0]];
        a_wq <= a_w[w_addr_a[3:0]];
        a_bq <= a_b[b_addr_a];
        if (mac_en_a) acc_a <= ((mac_iter_a == 9'd0) ? a_bq : acc_a) + a_dq * a_wq;
    end

    // ---------------- instance b (1 x 3) ----------------
    logic               start_b = 1'b0, busy_b, done_b, mac_en_b, res_we_b;
    logic [8:0]         in_addr_b, mac_iter_b;
    logic [11:0]        w_addr_b;
    logic [3:0]         b_addr_b, res_addr_b;
    logic signed [31:0] acc_b = 0, res_data_b;
    logic signed [31:0] b_data[16], b_w[16], b_b[16];
    logic signed [31:0] b_dq = 0, b_wq = 0, b_bq = 0;

    linear_layer_ctrl #(.N_IN(NB_IN), .N_OUT(NB_OUT), .W_ADDR_W(12), .O_ADDR_W(4)) dut_b (
        .clk(clk), .rst_b(rst_b), .start(start_b), .busy(busy_b), .done(done_b),
        .in_addr(in_addr_b), .w_addr(w_addr_b), .b_addr(b_addr_b),
        .mac_en(mac_en_b), .mac_iter(mac_iter_b), .acc_in(acc_b),
        .res_we(res_we_b), .res_addr(res_addr_b), .res_data(res_data_b)
    );

    always @(posedge clk) begin
        b_dq <= b_data[in_addr_b[3:0]];
        b_wq <= b_w[w_addr_b[3:0]];
        b_bq <= b_b[b_addr_b];
        if (mac_en_b) acc_b <= ((mac_iter_b == 9'd0) ? b_bq : acc_b) + b_dq * b_wq;
    end

    // ---------------- checking helpers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at t=%0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    function automatic logic [31:0] exp_res(input int id, input int o);
        logic signed [31:0] s;
        if (id == 0) begin
            s = a_b[o];
            for (int i = 0; i < NA_IN; i++) s += a_data[i] * a_w[o*NA_IN + i];
        end else begin
            s = b_b[o];
            for (int i = 0; i < NB_IN; i++) s += b_data[i] * b_w[o*NB_IN + i];
        end
`ifdef LINEAR_CTRL_RELU_EN
        if (s < 0) s = 0;
`endif
        return s;
    endfunction

    // Model: position within a run, counted from the first busy cycle (0 = idle).
    function automatic int next_t(input int t, input logic s, input int n, input int m);
        if (t == 0) return s ? 1 : 0;
        if (t == m*(n+2) + 1) return 0;
        return t + 1;
    endfunction

    int t_a = 0, t_b = 0;
    always @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            t_a <= 0;
            t_b <= 0;
        end else begin
            t_a <= next_t(t_a, start_a, NA_IN, NA_OUT);
            t_b <= next_t(t_b, start_b, NB_IN, NB_OUT);
        end
    end

    task automatic check_inst(input string tag, input int id, input int t, input int n, input int m,
                              input logic busy, input logic done, input logic [31:0] in_addr,
                              input logic [31:0] w_addr, input logic [31:0] b_addr, input logic mac_en,
                              input logic [31:0] mac_iter, input logic res_we,
                              input logic [31:0] res_addr, input logic [31:0] res_data);
        int p, o;
        logic e_run, e_mac, e_we;
        p = (t >= 1) ? (t - 1) % (n + 2) : 0;
        o = (t >= 1) ? (t - 1) / (n + 2) : 0;
        e_run = (t >= 1) && (t <= m*(n+2)) && (p < n);
        e_mac = (t >= 1) && (t <= m*(n+2)) && (p >= 1) && (p <= n);
        e_we  = (t >= 1) && (t <= m*(n+2)) && (p == n + 1);
        check({tag, ".busy"}, 32'(busy), 32'(t != 0));
        check({tag, ".done"}, 32'(done), 32'(t == m*(n+2) + 1));
        check({tag, ".mac_en"}, 32'(mac_en), 32'(e_mac));
        check({tag, ".res_we"}, 32'(res_we), 32'(e_we));
        if (e_run) begin
            check({tag, ".in_addr"}, in_addr, 32'(p));
            check({tag, ".w_addr"}, w_addr, 32'(o*n + p));
            check({tag, ".b_addr"}, b_addr, 32'(o));
        end
        if (e_mac) check({tag, ".mac_iter"}, mac_iter, 32'(p - 1));
        if (e_we) begin
            check({tag, ".res_addr"}, res_addr, 32'(o));
            check({tag, ".res_data"}, res_data, exp_res(id, o));
        end
    endtask

    always @(negedge clk) begin
        check_inst("a", 0, t_a, NA_IN, NA_OUT, busy_a, done_a, 32'(in_addr_a), 32'(w_addr_a),
                   32'(b_addr_a), mac_en_a, 32'(mac_iter_a), res_we_a, 32'(res_addr_a), res_data_a);
        check_inst("b", 1, t_b, NB_IN, NB_OUT, busy_b, done_b, 32'(in_addr_b), 32'(w_addr_b),
                   32'(b_addr_b), mac_en_b, 32'(mac_iter_b), res_we_b, 32'(res_addr_b), res_data_b);
    end

    // ---------------- observation logs for literal checks ----------------
    int base_a = 0, base_b = 0;
    int wr_a = 0, wr_b = 0, done_at_a = -1, done_at_b = -1, n_done_a = 0, busy_cnt_a = 0;
    logic [31:0] log_a[16], log_b[16];

    always @(negedge clk) begin
        if (res_we_a) begin log_a[res_addr_a] = res_data_a; wr_a++; end
        if (res_we_b) begin log_b[res_addr_b] = res_data_b; wr_b++; end
        if (done_a) begin done_at_a = cyc - base_a; n_done_a++; end
        if (done_b) done_at_b = cyc - base_b;
        if (busy_a) busy_cnt_a++;
    end

    task automatic clear_logs();
        for (int i = 0; i < 16; i++) begin
            log_a[i] = 32'hDEADBEEF;
            log_b[i] = 32'hDEADBEEF;
        end
        wr_a = 0; wr_b = 0; done_at_a = -1; done_at_b = -1; n_done_a = 0; busy_cnt_a = 0;
    endtask

    // Cycle k of a run is the cycle whose cyc equals base + k; inputs change 1 ns after the edge.
    task automatic goto_a(input int c);
        while (cyc - base_a < c) begin @(posedge clk); #1; end
    endtask

    task automatic goto_b(input int c);
        while (cyc - base_b < c) begin @(posedge clk); #1; end
    endtask

    task automatic begin_a();
        @(posedge clk); #1;
        start_a = 1'b1;
        base_a = cyc;
        @(posedge clk); #1;
        start_a = 1'b0;
    endtask

    task automatic load_a(input int d, input int w, input int b0, input int b1);
        for (int i = 0; i < 16; i++) begin
            a_data[i] = d;
            a_w[i] = w;
            a_b[i] = 0;
        end
        a_b[0] = b0;
        a_b[1] = b1;
    endtask

    initial begin
        load_a(1, 1, 10, 20);
        for (int i = 0; i < 16; i++) begin
            b_data[i] = 2;
            b_w[i] = 5;
            b_b[i] = 0;
        end
        b_b[1] = 1;
        b_b[2] = 2;
        clear_logs();

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("reset.busy", 32'(busy_a), 0);
        check("reset.done", 32'(done_a), 0);
        check("reset.mac_en", 32'(mac_en_a), 0);
        check("reset.res_we", 32'(res_we_a), 0);
        check("reset.w_addr", 32'(w_addr_a), 0);
        check("reset.res_data", res_data_a, 0);
        rst_b = 1'b1;

        // Basic run with start pulses at cycle 3 and during DONE that must be ignored
        begin_a();
        goto_a(3);  start_a = 1'b1;
        goto_a(4);  start_a = 1'b0;
        goto_a(13); start_a = 1'b1;
        goto_a(14); start_a = 1'b0;
        goto_a(24);
        check("run1.res0", log_a[0], 32'd14);
        check("run1.res1", log_a[1], 32'd24);
        check("run1.writes", 32'(wr_a), 32'd2);
        check("run1.done_cycle", 32'(done_at_a), 32'd13);
        check("run1.done_count", 32'(n_done_a), 32'd1);
        check("run1.busy_cycles", 32'(busy_cnt_a), 32'd13);

        // start held from DONE: new run begins in cycle 15
        clear_logs();
        begin_a();
        goto_a(13); start_a = 1'b1;
        goto_a(14);
        check("hold.busy_c14", 32'(busy_a), 32'd0);
        goto_a(15);
        check("hold.busy_c15", 32'(busy_a), 32'd1);
        start_a = 1'b0;
        goto_a(30);
        check("hold.done_count", 32'(n_done_a), 32'd2);
        check("hold.done_cycle", 32'(done_at_a), 32'd27);
        check("hold.res0", log_a[0], 32'd14);
        check("hold.res1", log_a[1], 32'd24);

        // Reset mid-run at cycle 5
        clear_logs();
        begin_a();
        goto_a(5);
        rst_b = 1'b0;
        #1;
        check("abort.busy", 32'(busy_a), 32'd0);
        check("abort.mac_en", 32'(mac_en_a), 32'd0);
        check("abort.res_we", 32'(res_we_a), 32'd0);
        goto_a(8);
        rst_b = 1'b1;
        goto_a(14);
        check("abort.no_write", 32'(wr_a), 32'd0);
        begin_a();
        goto_a(16);
        check("rerun.res0", log_a[0], 32'd14);
        check("rerun.res1", log_a[1], 32'd24);
        check("rerun.done_cycle", 32'(done_at_a), 32'd13);

        // Negative accumulator
        clear_logs();
        load_a(1, -3, 2, 2);
        begin_a();
        goto_a(16);
`ifdef LINEAR_CTRL_RELU_EN
        check("neg.res0", log_a[0], 32'd0);
        check("neg.res1", log_a[1], 32'd0);
`else
        check("neg.res0", log_a[0], 32'hFFFFFFF6);
        check("neg.res1", log_a[1], 32'hFFFFFFF6);
`endif

        // Single-feature configuration
        clear_logs();
        @(posedge clk); #1;
        start_b = 1'b1;
        base_b = cyc;
        @(posedge clk); #1;
        start_b = 1'b0;
        goto_b(14);
        check("nin1.res0", log_b[0], 32'd10);
        check("nin1.res1", log_b[1], 32'd11);
        check("nin1.res2", log_b[2], 32'd12);
        check("nin1.writes", 32'(wr_b), 32'd3);
        check("nin1.done_cycle", 32'(done_at_b), 32'd10);

        @(posedge clk); #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
